// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter slice:
// opcode encodings, arbiter FSM states and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } arb_state_e;

    // True for the five opcodes the datapath implements.
    function automatic logic is_legal_op(input logic [2:0] ctrl);
        logic legal;
        case (ctrl)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath shared by the arbiter's requesters.
// Arithmetic wraps modulo 2^WIDTH; unknown opcodes yield zero and flag illegal.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // Opcode decode and operation select; the product keeps only the low WIDTH bits.
    always_comb begin
        result  = '0;
        illegal = !is_legal_op(ctrl);
        case (ctrl)
            OP_AND:  result = data1 & data2;
            OP_OR:   result = data1 | data2;
            OP_ADD:  result = data1 + data2;
            OP_SUB:  result = data1 - data2;
            OP_MUL:  result = data1 * data2;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU (alu_core).
// IDLE grants one requester (round robin on ties), EXEC computes, RESP holds
// the registered response until the consumer accepts it.
// Optional macro ALU_ARB_MUL_MULTICYCLE_EN: multiply occupies EXEC for
// MUL_CYCLES cycles; without it every opcode takes a single EXEC cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = ALU_WIDTH,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             r0_valid_i,
    output logic             r0_ready_o,
    input  logic [WIDTH-1:0] r0_data1_i,
    input  logic [WIDTH-1:0] r0_data2_i,
    input  logic [2:0]       r0_ctrl_i,
    input  logic             r1_valid_i,
    output logic             r1_ready_o,
    input  logic [WIDTH-1:0] r1_data1_i,
    input  logic [WIDTH-1:0] r1_data2_i,
    input  logic [2:0]       r1_ctrl_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_id_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("alu_arbiter: MUL_CYCLES must be in 2..15");
    end

    arb_state_e       state;
    logic             last_grant;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_ctrl;
    logic             op_id;

    logic             resp_valid_q;
    logic             resp_id_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_illegal;

    logic             grant0;
    logic             grant1;
    logic             exec_done;

    // Tie goes to the requester that did not win the previous grant.
    assign grant0 = r0_valid_i && (!r1_valid_i || last_grant);
    assign grant1 = r1_valid_i && (!r0_valid_i || !last_grant);

    assign r0_ready_o = (state == ST_IDLE) && grant0;
    assign r1_ready_o = (state == ST_IDLE) && grant1;

`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);
    logic [3:0] mul_cnt;
    assign exec_done = (op_ctrl != OP_MUL) || (mul_cnt == '0);
`else
    assign exec_done = 1'b1;
`endif

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .data1   (op_a),
        .data2   (op_b),
        .ctrl    (op_ctrl),
        .result  (core_result),
        .zero    (core_zero),
        .illegal (core_illegal)
    );

    // Arbiter FSM: capture the granted operation, run it, hold the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            op_a         <= '0;
            op_b         <= '0;
            op_ctrl      <= '0;
            op_id        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
            mul_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        op_a       <= grant1 ? r1_data1_i : r0_data1_i;
                        op_b       <= grant1 ? r1_data2_i : r0_data2_i;
                        op_ctrl    <= grant1 ? r1_ctrl_i  : r0_ctrl_i;
                        op_id      <= grant1;
                        last_grant <= grant1;
                        state      <= ST_EXEC;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
                        mul_cnt    <= MUL_CNT_INIT;
`endif
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        result_q     <= core_result;
                        zero_q       <= core_zero;
                        illegal_q    <= core_illegal;
                        resp_id_q    <= op_id;
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
                    else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
`endif
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign result_o     = result_q;
    assign zero_o       = zero_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are queued when an
// operation is accepted and compared while the DUT presents its response.
// Honors ALU_ARB_MUL_MULTICYCLE_EN for the expected multiply latency.
module tb_alu_arbiter;

    localparam int unsigned W     = 32;
    localparam int unsigned MULC  = 4;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    localparam bit          MC_EN = 1'b1;
`else
    localparam bit          MC_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          r0_valid_i = 1'b0, r1_valid_i = 1'b0;
    logic          r0_ready_o, r1_ready_o;
    logic [W-1:0]  r0_data1_i = '0, r0_data2_i = '0, r1_data1_i = '0, r1_data2_i = '0;
    logic [2:0]    r0_ctrl_i = '0, r1_ctrl_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic          resp_id_o;
    logic [W-1:0]  result_o;
    logic          zero_o, illegal_o;

    alu_arbiter #(
        .WIDTH      (W),
        .MUL_CYCLES (MULC)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .r0_valid_i   (r0_valid_i),
        .r0_ready_o   (r0_ready_o),
        .r0_data1_i   (r0_data1_i),
        .r0_data2_i   (r0_data2_i),
        .r0_ctrl_i    (r0_ctrl_i),
        .r1_valid_i   (r1_valid_i),
        .r1_ready_o   (r1_ready_o),
        .r1_data1_i   (r1_data1_i),
        .r1_data2_i   (r1_data2_i),
        .r1_ctrl_i    (r1_ctrl_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_id_o    (resp_id_o),
        .result_o     (result_o),
        .zero_o       (zero_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           id;
        logic [W-1:0] result;
        bit           zero;
        bit           illegal;
        int unsigned  lat;
        int unsigned  acc_cyc;
    } exp_t;

    exp_t        sb[$];
    bit          acc_order[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          prev_rv = 1'b0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit id, input logic [2:0] ctrl,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [63:0]  prod;
        e.id      = id;
        e.illegal = 1'b0;
        e.result  = '0;
        case (ctrl)
            3'b000: e.result = a & b;
            3'b001: e.result = a | b;
            3'b010: e.result = a + b;
            3'b011: e.result = a - b;
            3'b111: begin
                prod     = 64'(a) * 64'(b);
                e.result = prod[W-1:0];
            end
            default: e.illegal = 1'b1;
        endcase
        e.zero    = (e.result == 0);
        e.lat     = (ctrl == 3'b111 && MC_EN) ? MULC : 1;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Acceptance monitor and response checker.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            prev_rv = 1'b0;
        end else begin
            if (r0_valid_i && r0_ready_o) begin
                e = model(1'b0, r0_ctrl_i, r0_data1_i, r0_data2_i);
                e.acc_cyc = cyc;
                sb.push_back(e);
                acc_order.push_back(1'b0);
            end
            if (r1_valid_i && r1_ready_o) begin
                e = model(1'b1, r1_ctrl_i, r1_data1_i, r1_data2_i);
                e.acc_cyc = cyc;
                sb.push_back(e);
                acc_order.push_back(1'b1);
            end
            if (resp_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb[0];
                    if (!prev_rv)
                        chk("latency", 64'(cyc - e.acc_cyc - 1), 64'(e.lat));
                    chk("resp_id", 64'(resp_id_o), 64'(e.id));
                    chk("result", 64'(result_o), 64'(e.result));
                    chk("zero", 64'(zero_o), 64'(e.zero));
                    chk("illegal", 64'(illegal_o), 64'(e.illegal));
                    chk("r0_ready_in_resp", 64'(r0_ready_o), 64'd0);
                    chk("r1_ready_in_resp", 64'(r1_ready_o), 64'd0);
                    if (resp_ready_i) void'(sb.pop_front());
                end
            end
            prev_rv = resp_valid_o;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        chk({tag, "_resp_id"},    64'(resp_id_o),    64'd0);
        chk({tag, "_result"},     64'(result_o),     64'd0);
        chk({tag, "_zero"},       64'(zero_o),       64'd0);
        chk({tag, "_illegal"},    64'(illegal_o),    64'd0);
    endtask

    task automatic do_reset();
        r0_valid_i = 1'b0;
        r1_valid_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("rst_hold");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        acc_order.delete();
        @(negedge clk_i);
        check_reset_outputs("rst_post");
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input bit id, input logic [2:0] ctrl,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned n = 0;
        if (id) begin
            r1_valid_i = 1'b1; r1_ctrl_i = ctrl; r1_data1_i = a; r1_data2_i = b;
        end else begin
            r0_valid_i = 1'b1; r0_ctrl_i = ctrl; r0_data1_i = a; r0_data2_i = b;
        end
        do begin
            @(negedge clk_i);
            n++;
        end while (!(id ? r1_ready_o : r0_ready_o) && n < 100);
        chk("accept_timeout", 64'(n < 100), 64'd1);
        @(posedge clk_i);
        #1;
        if (id) r1_valid_i = 1'b0;
        else    r0_valid_i = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [2:0] ops[5];
        int unsigned n;
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b011; ops[4] = 3'b111;

        @(posedge clk_i);
        #1;
        do_reset();

        // Single add, consumer always ready.
        resp_ready_i = 1'b1;
        issue(1'b0, 3'b010, 32'd5, 32'd7);
        drain();

        // Both requesters valid continuously: grants alternate starting with r0.
        do_reset();
        r0_valid_i = 1'b1; r0_ctrl_i = 3'b011; r0_data1_i = 32'd3; r0_data2_i = 32'd3;
        r1_valid_i = 1'b1; r1_ctrl_i = 3'b001; r1_data1_i = 32'd0; r1_data2_i = 32'd0;
        n = 0;
        while (acc_order.size() < 4 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        r0_valid_i = 1'b0;
        r1_valid_i = 1'b0;
        drain();
        chk("grant_count", 64'(acc_order.size()), 64'd4);
        if (acc_order.size() >= 4) begin
            chk("grant0", 64'(acc_order[0]), 64'd0);
            chk("grant1", 64'(acc_order[1]), 64'd1);
            chk("grant2", 64'(acc_order[2]), 64'd0);
            chk("grant3", 64'(acc_order[3]), 64'd1);
        end

        // Wrapping multiply from r1.
        issue(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd2);
        drain();

        // Illegal opcode held in RESP while r1 waits.
        resp_ready_i = 1'b0;
        issue(1'b0, 3'b100, 32'h1234, 32'h5678);
        r1_valid_i = 1'b1; r1_ctrl_i = 3'b010; r1_data1_i = 32'd1; r1_data2_i = 32'd2;
        repeat (7) @(negedge clk_i);
        chk("r1_waits", 64'(sb.size()), 64'd1);
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!r1_ready_o && n < 100);
        chk("r1_late_accept", 64'(n < 100), 64'd1);
        @(posedge clk_i);
        #1;
        r1_valid_i = 1'b0;
        drain();

        // Reset during EXEC of a multiply discards it.
        issue(1'b1, 3'b111, 32'd3, 32'd4);
        do_reset();
        repeat (8) begin
            @(negedge clk_i);
            chk("no_resp_after_rst", 64'(resp_valid_o), 64'd0);
        end
        @(posedge clk_i);
        #1;
        issue(1'b1, 3'b010, 32'd1, 32'd1);
        drain();

        // Add wrapping to zero.
        issue(1'b0, 3'b010, 32'h8000_0000, 32'h8000_0000);
        drain();

        // A few random legal operations from alternating requesters.
        for (int i = 0; i < 6; i++) begin
            issue(1'(i), ops[$urandom_range(0, 4)], $urandom, $urandom);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
